// File: rtl/dm9000a_pkg.sv
// Shared constants and state type for the DM9000A EEPROM/PHY access path.
package dm9000a_pkg;

  localparam logic [7:0] REG_EPCR  = 8'h0B;
  localparam logic [7:0] REG_EPAR  = 8'h0C;
  localparam logic [7:0] REG_EPDRL = 8'h0D;
  localparam logic [7:0] REG_EPDRH = 8'h0E;

  localparam logic [7:0] EPCR_PHY_WR = 8'h0A;
  localparam logic [7:0] EPCR_PHY_RD = 8'h0C;
  localparam logic [7:0] EPCR_EE_WR  = 8'h12;
  localparam logic [7:0] EPCR_EE_RD  = 8'h04;
  localparam logic [7:0] EPCR_CLR    = 8'h00;
  localparam int         ERRE_BIT    = 0;

  // One-hot engine select: bit order matches the bus_step start/done vectors
  localparam logic [2:0] ENG_IOW = 3'b001;
  localparam logic [2:0] ENG_IOR = 3'b010;
  localparam logic [2:0] ENG_DLY = 3'b100;

  typedef enum logic [3:0] {
    S_IDLE, S_W_EPAR, S_W_EPDRH, S_W_EPDRL, S_W_CMD, S_POLL_DLY,
    S_POLL_RD, S_W_CLR, S_R_EPDRH, S_R_EPDRL, S_DONE, S_ABORT_CLR
  } ep_state_e;

  function automatic logic [7:0] epcr_cmd(input logic rd, input logic ee);
    if (ee) return rd ? EPCR_EE_RD : EPCR_EE_WR;
    return rd ? EPCR_PHY_RD : EPCR_PHY_WR;
  endfunction

endpackage

// File: rtl/dm9000a_bus_step.sv
// Engine handshake: raise one start line, hold until its done, drop, leave one idle cycle.
module dm9000a_bus_step #(
  parameter int N = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req_i,
  input  logic         abort_i,
  input  logic [N-1:0] sel_i,
  input  logic [N-1:0] done_i,
  output logic [N-1:0] start_o,
  output logic         launch_o,
  output logic         fin_o
);

  logic [N-1:0] start_q, start_d;

  // Done lines of engines we are not driving are stale and ignored
  assign launch_o = req_i && !abort_i && (start_q == '0);
  assign fin_o    = !abort_i && |(done_i & start_q);
  assign start_o  = start_q;

  always_comb begin
    start_d = start_q;
    if (abort_i || fin_o) start_d = '0;
    else if (launch_o)    start_d = sel_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) start_q <= '0;
    else         start_q <= start_d;
  end

endmodule

// File: rtl/dm9000a_ep_access.sv
// PHY/EEPROM word access sequencer over EPAR/EPDRH/EPDRL/EPCR with ERRE polling.
// Define DM9000A_EEPROM_EN to honour iTarget; otherwise every access goes to the PHY.
module dm9000a_ep_access
  import dm9000a_pkg::*;
#(
  parameter logic [1:0]  PHY_ADDR   = 2'b01,
  parameter logic [10:0] POLL_DELAY = 11'd25,
  parameter int          POLL_MAX   = 200
) (
  input  logic        iDm9000aClk,
  input  logic        iRst_n,
  input  logic        iRunStart,
  input  logic        iOp,
  input  logic        iTarget,
  input  logic [7:0]  iReg,
  input  logic [15:0] iValue,
  output logic        oRunEnd,
  output logic [15:0] oReadData,
  output logic        oTimeout,
  output logic        out_to_Dm9000a_Iow_RunStart,
  output logic [15:0] out_to_Dm9000a_Iow_Reg,
  output logic [15:0] out_to_Dm9000a_Iow_Data,
  input  logic        in_from_Dm9000a_Iow_RunEnd,
  output logic        out_to_Dm9000a_Ior_RunStart,
  output logic [15:0] out_to_Dm9000a_Ior_Reg,
  input  logic        in_from_Dm9000a_Ior_RunEnd,
  input  logic [15:0] in_from_Dm9000a_Ior_Data,
  output logic        out_to_Dm9000a_usDelay_RunStart,
  output logic [10:0] out_to_Dm9000a_usDelay_DelayTime,
  input  logic        in_from_Dm9000a_usDelay_RunEnd
);

  localparam int PCW = $clog2(POLL_MAX + 1);

  ep_state_e   state_q, state_d;
  logic        op_q, op_d, tmo_q, tmo_d, runend_q;
  logic [7:0]  reg_q, reg_d;
  logic [15:0] val_q, val_d, rdata_q, rdata_d;
  logic [PCW-1:0] pcnt_q, pcnt_d, pcnt_inc;
  logic [15:0] iow_reg_q, iow_reg_d, iow_data_q, iow_data_d, ior_reg_q, ior_reg_d;
  logic [10:0] dly_q, dly_d;
  logic [15:0] epar;
  logic [7:0]  cmd, bus_reg;
  logic [15:0] bus_dat;
  logic [2:0]  sel, start;
  logic        req, launch, fin, abort, pre_cmd;
  logic        unused_hi;

`ifdef DM9000A_EEPROM_EN
  logic tgt_q;
  always_ff @(posedge iDm9000aClk or negedge iRst_n) begin
    if (!iRst_n)                            tgt_q <= 1'b0;
    else if (state_q == S_IDLE && iRunStart) tgt_q <= iTarget;
  end
  assign epar = tgt_q ? {8'h00, reg_q} : {8'h00, PHY_ADDR, reg_q[5:0]};
  assign cmd  = epcr_cmd(op_q, tgt_q);
`else
  logic unused_cfg;
  assign unused_cfg = iTarget ^ reg_q[7] ^ reg_q[6];
  assign epar = {8'h00, PHY_ADDR, reg_q[5:0]};
  assign cmd  = epcr_cmd(op_q, 1'b0);
`endif

  assign unused_hi = ^in_from_Dm9000a_Ior_Data[15:8];
  assign pcnt_inc  = (pcnt_q == PCW'(POLL_MAX)) ? pcnt_q : pcnt_q + 1'b1;
  assign abort     = !iRunStart && !(state_q inside {S_IDLE, S_DONE, S_ABORT_CLR});
  assign pre_cmd   = state_q inside {S_W_EPAR, S_W_EPDRH, S_W_EPDRL, S_W_CMD};

  dm9000a_bus_step #(.N(3)) u_step (
    .clk_i    (iDm9000aClk),
    .rst_ni   (iRst_n),
    .req_i    (req),
    .abort_i  (abort),
    .sel_i    (sel),
    .done_i   ({in_from_Dm9000a_usDelay_RunEnd, in_from_Dm9000a_Ior_RunEnd,
                in_from_Dm9000a_Iow_RunEnd}),
    .start_o  (start),
    .launch_o (launch),
    .fin_o    (fin)
  );

  always_comb begin
    state_d = state_q; op_d = op_q; reg_d = reg_q; val_d = val_q;
    pcnt_d = pcnt_q; tmo_d = tmo_q; rdata_d = rdata_q;
    iow_reg_d = iow_reg_q; iow_data_d = iow_data_q; ior_reg_d = ior_reg_q; dly_d = dly_q;
    req = 1'b0; sel = ENG_IOW; bus_reg = 8'h00; bus_dat = 16'h0000;
    case (state_q)
      S_IDLE: if (iRunStart) begin
        state_d = S_W_EPAR; op_d = iOp; reg_d = iReg; val_d = iValue;
        pcnt_d = '0; tmo_d = 1'b0; rdata_d = '0;
      end
      S_W_EPAR: begin
        req = 1'b1; bus_reg = REG_EPAR; bus_dat = epar;
        if (fin) state_d = op_q ? S_W_CMD : S_W_EPDRH;
      end
      S_W_EPDRH: begin
        req = 1'b1; bus_reg = REG_EPDRH; bus_dat = {8'h00, val_q[15:8]};
        if (fin) state_d = S_W_EPDRL;
      end
      S_W_EPDRL: begin
        req = 1'b1; bus_reg = REG_EPDRL; bus_dat = {8'h00, val_q[7:0]};
        if (fin) state_d = S_W_CMD;
      end
      S_W_CMD: begin
        req = 1'b1; bus_reg = REG_EPCR; bus_dat = {8'h00, cmd};
        if (fin) state_d = S_POLL_DLY;
      end
      S_POLL_DLY: begin
        req = 1'b1; sel = ENG_DLY;
        if (fin) state_d = S_POLL_RD;
      end
      S_POLL_RD: begin
        req = 1'b1; sel = ENG_IOR; bus_reg = REG_EPCR;
        if (fin) begin
          if (!in_from_Dm9000a_Ior_Data[ERRE_BIT]) state_d = S_W_CLR;
          else begin
            pcnt_d = pcnt_inc;
            if (pcnt_inc == PCW'(POLL_MAX)) begin tmo_d = 1'b1; state_d = S_W_CLR; end
            else state_d = S_POLL_DLY;
          end
        end
      end
      S_W_CLR: begin
        req = 1'b1; bus_reg = REG_EPCR; bus_dat = {8'h00, EPCR_CLR};
        if (fin) state_d = (op_q && !tmo_q) ? S_R_EPDRH : S_DONE;
      end
      S_R_EPDRH: begin
        req = 1'b1; sel = ENG_IOR; bus_reg = REG_EPDRH;
        if (fin) begin rdata_d[15:8] = in_from_Dm9000a_Ior_Data[7:0]; state_d = S_R_EPDRL; end
      end
      S_R_EPDRL: begin
        req = 1'b1; sel = ENG_IOR; bus_reg = REG_EPDRL;
        if (fin) begin rdata_d[7:0] = in_from_Dm9000a_Ior_Data[7:0]; state_d = S_DONE; end
      end
      S_DONE: if (!iRunStart) state_d = S_IDLE;
      S_ABORT_CLR: begin
        req = 1'b1; bus_reg = REG_EPCR; bus_dat = {8'h00, EPCR_CLR};
        if (fin) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Once the command is in EPCR it must be cleared even when abandoning
    if (abort) state_d = pre_cmd ? S_IDLE : S_ABORT_CLR;
    if (launch) begin
      if (sel == ENG_IOW) begin iow_reg_d = {8'h00, bus_reg}; iow_data_d = bus_dat; end
      else if (sel == ENG_IOR) ior_reg_d = {8'h00, bus_reg};
      else dly_d = POLL_DELAY;
    end
  end

  always_ff @(posedge iDm9000aClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= S_IDLE; op_q <= 1'b0; reg_q <= '0; val_q <= '0;
      pcnt_q <= '0; tmo_q <= 1'b0; rdata_q <= '0; runend_q <= 1'b0;
      iow_reg_q <= '0; iow_data_q <= '0; ior_reg_q <= '0; dly_q <= '0;
    end else begin
      state_q <= state_d; op_q <= op_d; reg_q <= reg_d; val_q <= val_d;
      pcnt_q <= pcnt_d; tmo_q <= tmo_d; rdata_q <= rdata_d;
      runend_q <= (state_d == S_DONE);
      iow_reg_q <= iow_reg_d; iow_data_q <= iow_data_d; ior_reg_q <= ior_reg_d; dly_q <= dly_d;
    end
  end

  assign oRunEnd   = runend_q;
  assign oReadData = rdata_q;
  assign oTimeout  = tmo_q;
  assign out_to_Dm9000a_Iow_RunStart      = start[0];
  assign out_to_Dm9000a_Iow_Reg           = iow_reg_q;
  assign out_to_Dm9000a_Iow_Data          = iow_data_q;
  assign out_to_Dm9000a_Ior_RunStart      = start[1];
  assign out_to_Dm9000a_Ior_Reg           = ior_reg_q;
  assign out_to_Dm9000a_usDelay_RunStart  = start[2];
  assign out_to_Dm9000a_usDelay_DelayTime = dly_q;

endmodule

// File: tb/tb_dm9000a_ep_access.sv
// Randomized bench: engine models log every bus step, compared with a sequence built from the access rules.
module tb_dm9000a_ep_access;

  localparam int          PMAX = 4;
  localparam logic [10:0] PDLY = 11'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, run, op, tgt;
  logic [7:0]  rg;
  logic [15:0] val;
  logic        run_end, tmo;
  logic [15:0] rdata;
  logic        iow_st, ior_st, dly_st;
  logic [15:0] iow_reg, iow_data, ior_reg;
  logic [10:0] dly_t;
  logic        iow_end = 1'b0, ior_end = 1'b0, dly_end = 1'b0;
  logic [15:0] ior_data = 16'h0;

  dm9000a_ep_access #(.PHY_ADDR(2'b01), .POLL_DELAY(PDLY), .POLL_MAX(PMAX)) dut (
    .iDm9000aClk(clk), .iRst_n(rst_n), .iRunStart(run), .iOp(op), .iTarget(tgt),
    .iReg(rg), .iValue(val), .oRunEnd(run_end), .oReadData(rdata), .oTimeout(tmo),
    .out_to_Dm9000a_Iow_RunStart(iow_st), .out_to_Dm9000a_Iow_Reg(iow_reg),
    .out_to_Dm9000a_Iow_Data(iow_data), .in_from_Dm9000a_Iow_RunEnd(iow_end),
    .out_to_Dm9000a_Ior_RunStart(ior_st), .out_to_Dm9000a_Ior_Reg(ior_reg),
    .in_from_Dm9000a_Ior_RunEnd(ior_end), .in_from_Dm9000a_Ior_Data(ior_data),
    .out_to_Dm9000a_usDelay_RunStart(dly_st), .out_to_Dm9000a_usDelay_DelayTime(dly_t),
    .in_from_Dm9000a_usDelay_RunEnd(dly_end)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Engine models: log entry = {engine, reg, data}; engine 0=Iow 1=Ior 2=delay
  logic [33:0] log_q[$];
  int   poll_k = 0, poll_gen = 0, seen_gen = -1, ones_left = 0;
  logic [7:0] hb = 8'h0, lb = 8'h0;
  int   iow_cnt, ior_cnt, dly_cnt, glitch = 0, overlap = 0, runend_cnt = 0;
  logic iow_busy = 0, ior_busy = 0, dly_busy = 0, erre;
  logic [15:0] iow_r, iow_d, ior_r, rnd;
  logic [10:0] dly_c;

  always @(negedge clk) begin
    rnd = 16'($urandom);
    if (!iow_st) begin iow_end = 0; iow_busy = 0; end
    else if (!iow_busy) begin
      iow_busy = 1; iow_cnt = $urandom_range(0, 3); iow_r = iow_reg; iow_d = iow_data;
      log_q.push_back({2'd0, iow_reg, iow_data});
    end else begin
      if (iow_reg !== iow_r || iow_data !== iow_d) glitch++;
      if (!iow_end) begin if (iow_cnt == 0) iow_end = 1; else iow_cnt--; end
    end
    if (!ior_st) begin ior_end = 0; ior_busy = 0; end
    else if (!ior_busy) begin
      ior_busy = 1; ior_cnt = $urandom_range(0, 3); ior_r = ior_reg;
      log_q.push_back({2'd1, ior_reg, 16'h0});
    end else begin
      if (ior_reg !== ior_r) glitch++;
      if (!ior_end && ior_cnt == 0) begin
        ior_end = 1;
        case (ior_r)
          16'h000B: begin
            if (seen_gen != poll_gen) begin seen_gen = poll_gen; ones_left = poll_k; end
            erre = (ones_left > 0);
            if (erre) ones_left--;
            ior_data = {rnd[15:1], erre};
          end
          16'h000E: ior_data = {rnd[15:8], hb};
          16'h000D: ior_data = {rnd[15:8], lb};
          default:  ior_data = rnd;
        endcase
      end else if (!ior_end) ior_cnt--;
    end
    if (!dly_st) begin dly_end = 0; dly_busy = 0; end
    else if (!dly_busy) begin
      dly_busy = 1; dly_cnt = $urandom_range(0, 3); dly_c = dly_t;
      log_q.push_back({2'd2, 16'h0, 5'd0, dly_t});
    end else begin
      if (dly_t !== dly_c) glitch++;
      if (!dly_end) begin if (dly_cnt == 0) dly_end = 1; else dly_cnt--; end
    end
    if (int'(iow_st) + int'(ior_st) + int'(dly_st) > 1) overlap++;
    if (run_end) runend_cnt++;
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_a"}, {run_end, tmo, rdata, iow_st, iow_reg, iow_data}, 64'h0);
    chk({tag, "_b"}, {ior_st, ior_reg, dly_st, dly_t}, 64'h0);
  endtask

  task automatic launch(input logic o, input logic t, input logic [7:0] r, input logic [15:0] v,
                        input int k, input logic [7:0] h, input logic [7:0] l);
    @(negedge clk);
    log_q.delete(); poll_k = k; poll_gen++; hb = h; lb = l;
    op = o; tgt = t; rg = r; val = v; run = 1'b1;
  endtask

  task automatic run_op(input logic o, input logic t, input logic [7:0] r, input logic [15:0] v,
                        input int k, input logic [7:0] h, input logic [7:0] l);
    logic [33:0] exp_q[$];
    logic ee, to;
    logic [15:0] epar;
    logic [7:0] cmd;
    int reads, n;
`ifdef DM9000A_EEPROM_EN
    ee = t;
`else
    ee = 1'b0;
`endif
    epar  = ee ? {8'h00, r} : {8'h00, 2'b01, r[5:0]};
    cmd   = ee ? (o ? 8'h04 : 8'h12) : (o ? 8'h0C : 8'h0A);
    to    = (k >= PMAX);
    reads = to ? PMAX : k + 1;
    exp_q.push_back({2'd0, 16'h000C, epar});
    if (!o) begin
      exp_q.push_back({2'd0, 16'h000E, 8'h00, v[15:8]});
      exp_q.push_back({2'd0, 16'h000D, 8'h00, v[7:0]});
    end
    exp_q.push_back({2'd0, 16'h000B, 8'h00, cmd});
    for (int i = 0; i < reads; i++) begin
      exp_q.push_back({2'd2, 16'h0, 5'd0, PDLY});
      exp_q.push_back({2'd1, 16'h000B, 16'h0});
    end
    exp_q.push_back({2'd0, 16'h000B, 16'h0000});
    if (o && !to) begin
      exp_q.push_back({2'd1, 16'h000E, 16'h0});
      exp_q.push_back({2'd1, 16'h000D, 16'h0});
    end
    launch(o, t, r, v, k, h, l);
    for (int i = 0; i < 3000 && !run_end; i++) @(negedge clk);
    chk("run_end", run_end, 1'b1);
    chk("steps", log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("step%0d", i), log_q[i], exp_q[i]);
    chk("timeout", tmo, to);
    if (o) chk("rdata", rdata, (to ? 16'h0000 : {h, l}));
    chk("idle_in_done", {iow_st, ior_st, dly_st}, 3'b000);
    repeat (3) @(negedge clk);
    chk("run_end_held", run_end, 1'b1);
    run = 1'b0;
    repeat (2) @(negedge clk);
    chk("run_end_drop", run_end, 1'b0);
  endtask

  // where 0: drop request while EPAR is in flight; 1: drop during the first poll delay
  task automatic abort_run(input int where);
    int base;
    bit seen;
    base = runend_cnt;
    launch(1'b0, 1'b0, 8'h07, 16'h1234, 2, 8'h00, 8'h00);
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = (where == 0) ? iow_st : dly_st;
    end
    chk("abort_reach", seen, 1'b1);
    run = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_end", runend_cnt - base, 0);
    chk("abort_idle", {iow_st, ior_st, dly_st}, 3'b000);
    if (where == 0) chk("abort_early_steps", log_q.size(), 1);
    else begin
      chk("abort_late_steps", log_q.size(), 6);
      if (log_q.size() > 0) chk("abort_clr", log_q[log_q.size()-1], {2'd0, 16'h000B, 16'h0000});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; op = 1'b0; tgt = 1'b0; rg = 8'h0; val = 16'h0;
    #2;
    chk_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 1'b0, 8'h00, 16'h3100, 1, 8'h00, 8'h00);
    run_op(1'b1, 1'b0, 8'h01, 16'h0000, 0, 8'h78, 8'h2D);
    run_op(1'b1, 1'b0, 8'h03, 16'h0000, PMAX + 2, 8'hAA, 8'h55);
    run_op(1'b0, 1'b0, 8'hC2, 16'hBEEF, PMAX, 8'h00, 8'h00);
    run_op(1'b1, 1'b0, 8'h11, 16'h0000, PMAX - 1, 8'h12, 8'h34);
    run_op(1'b0, 1'b1, 8'h05, 16'hA55A, 0, 8'h00, 8'h00);
    abort_run(0);
    abort_run(1);

    // reset asserted while an ERRE poll read is outstanding
    launch(1'b1, 1'b0, 8'h02, 16'h0, 3, 8'h00, 8'h00);
    begin
      bit seen = 0;
      for (int i = 0; i < 500 && !seen; i++) begin @(negedge clk); seen = ior_st; end
      chk("poll_reach", seen, 1'b1);
    end
    rst_n = 1'b0; run = 1'b0;
    #1;
    chk_outputs_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b1, 1'b0, 8'h02, 16'h0, 1, 8'hC3, 8'h3C);

    for (int n = 0; n < 25; n++)
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
             $urandom_range(0, PMAX + 1), 8'($urandom), 8'($urandom));

    chk("bus_stable", glitch, 0);
    chk("one_engine", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
